// File: rtl/matraptor_pp_gen.sv
// MatRaptor partial-product generator.
// Takes one A nonzero at a time, reads the matching B row through its CSR row
// pointers, and streams a_val * b_val products through a 2-entry output FIFO.
module matraptor_pp_gen #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 16,
  parameter int unsigned PTR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // A nonzero stream
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_val,
  input  logic [IDX_W-1:0]  a_row,
  input  logic [IDX_W-1:0]  a_col,
  input  logic              a_last,
  // B row-pointer port
  output logic              b_rp_en,
  output logic [IDX_W-1:0]  b_rp_addr,
  input  logic [PTR_W-1:0]  b_rp_start,
  input  logic [PTR_W-1:0]  b_rp_end,
  // B element port
  output logic              b_el_en,
  output logic [PTR_W-1:0]  b_el_addr,
  input  logic [DATA_W-1:0] b_el_val,
  input  logic [IDX_W-1:0]  b_el_col,
  // Partial-product stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last,
  output logic              done
);

  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_PTR, S_STREAM} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic              last;
  } entry_t;

  state_e            state_q, state_d;
  logic              ready_q;
  logic [DATA_W-1:0] a_val_q, a_val_d;
  logic [IDX_W-1:0]  a_row_q, a_row_d;
  logic              a_last_q, a_last_d;
  logic [PTR_W-1:0]  cur_ptr_q, cur_ptr_d;
  logic [PTR_W-1:0]  end_ptr_q, end_ptr_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;

  entry_t            fifo_q [2];
  entry_t            fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              a_hs;
  logic              pop;
  logic              push;
  logic              space;
  logic              issue;
  logic              done_ptr;
  logic [2:0]        occupancy;
  logic [2:0]        limit;
  logic [DATA_W-1:0] product;
  entry_t            push_entry;
  entry_t            head;

  // Handshakes and issue gating; a read is allowed only if its data is
  // guaranteed a FIFO slot when it returns next cycle.
  always_comb begin
    a_hs      = a_valid && a_ready;
    pop       = out_valid && out_ready;
    push      = inflight_q;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    limit     = 3'd2 + {2'b00, pop};
    space     = occupancy < limit;
    issue     = (state_q == S_STREAM) && (cur_ptr_q < end_ptr_q) && space;
    product   = a_val_q * b_el_val;
  end

  // FSM next state, pointer capture and A-operand capture.
  always_comb begin
    state_d     = state_q;
    cur_ptr_d   = cur_ptr_q;
    end_ptr_d   = end_ptr_q;
    done_ptr    = 1'b0;
    a_val_d     = a_hs ? a_val  : a_val_q;
    a_row_d     = a_hs ? a_row  : a_row_q;
    a_last_d    = a_hs ? a_last : a_last_q;
    inflight_d  = issue;
    infl_last_d = issue && a_last_q && ((cur_ptr_q + PtrOne) == end_ptr_q);
    unique case (state_q)
      S_IDLE: begin
        if (a_hs) state_d = S_PTR;
      end
      S_PTR: begin
        cur_ptr_d = b_rp_start;
        end_ptr_d = b_rp_end;
        if (b_rp_start >= b_rp_end) begin
          // Empty B row: nothing to stream, but it may still close the matrix.
          state_d  = S_IDLE;
          done_ptr = a_last_q;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (issue) begin
          cur_ptr_d = cur_ptr_q + PtrOne;
          if (cur_ptr_d == end_ptr_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output FIFO bookkeeping; returning element data is always pushed.
  always_comb begin
    push_entry = '{val: product, row: a_row_q, col: b_el_col, last: infl_last_q};
    fifo_d     = fifo_q;
    if (push) fifo_d[wr_ptr_q] = push_entry;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Outputs: FIFO head plus the read strobes.
  always_comb begin
    head      = fifo_q[rd_ptr_q];
    a_ready   = ready_q && (state_q == S_IDLE);
    b_rp_en   = a_hs;
    b_rp_addr = a_col;
    b_el_en   = issue;
    b_el_addr = cur_ptr_q;
    out_valid = (count_q != 2'd0);
    out_val   = head.val;
    out_row   = head.row;
    out_col   = head.col;
    out_last  = out_valid && head.last;
    done      = done_ptr || (pop && head.last);
  end

  // State registers; ready_q holds a_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      a_val_q     <= '0;
      a_row_q     <= '0;
      a_last_q    <= 1'b0;
      cur_ptr_q   <= '0;
      end_ptr_q   <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      a_val_q     <= a_val_d;
      a_row_q     <= a_row_d;
      a_last_q    <= a_last_d;
      cur_ptr_q   <= cur_ptr_d;
      end_ptr_q   <= end_ptr_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < 2; i++) fifo_q[i] <= fifo_d[i];
    end
  end

endmodule

// File: tb/tb_matraptor_pp_gen.sv
// Self-checking bench for matraptor_pp_gen: directed timing scenarios followed by
// randomized matrices checked against a queue-based reference model.
module tb_matraptor_pp_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [31:0] a_val = '0;
  logic [15:0] a_row = '0;
  logic [15:0] a_col = '0;
  logic        a_last = 1'b0;
  logic        b_rp_en;
  logic [15:0] b_rp_addr;
  logic [15:0] b_rp_start = '0;
  logic [15:0] b_rp_end = '0;
  logic        b_el_en;
  logic [15:0] b_el_addr;
  logic [31:0] b_el_val = '0;
  logic [15:0] b_el_col = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_val;
  logic [15:0] out_row;
  logic [15:0] out_col;
  logic        out_last;
  logic        done;

  always #5 clk = ~clk;

  matraptor_pp_gen #(.DATA_W(32), .IDX_W(16), .PTR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_val      (a_val),
    .a_row      (a_row),
    .a_col      (a_col),
    .a_last     (a_last),
    .b_rp_en    (b_rp_en),
    .b_rp_addr  (b_rp_addr),
    .b_rp_start (b_rp_start),
    .b_rp_end   (b_rp_end),
    .b_el_en    (b_el_en),
    .b_el_addr  (b_el_addr),
    .b_el_val   (b_el_val),
    .b_el_col   (b_el_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_val    (out_val),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .done       (done)
  );

  // B matrix in CSR form: 16 rows, up to 64 elements.
  int unsigned rowptr [0:16];
  logic [31:0] bval [0:63];
  logic [15:0] bcol [0:63];

  // Synchronous memories with one-cycle read latency.
  always @(posedge clk) begin
    if (b_rp_en) begin
      b_rp_start <= 16'(rowptr[int'(b_rp_addr[3:0])]);
      b_rp_end   <= 16'(rowptr[int'(b_rp_addr[3:0]) + 1]);
    end
    if (b_el_en) begin
      b_el_val <= bval[b_el_addr[5:0]];
      b_el_col <= bcol[b_el_addr[5:0]];
    end
  end

  // out_ready: forced level for directed tests, random for the stress phase.
  bit   rand_ready = 1'b0;
  logic ready_force = 1'b1;
  logic rnd_ready = 1'b1;
  assign out_ready = rand_ready ? rnd_ready : ready_force;
  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] val;
    logic [15:0] row;
    logic [15:0] col;
    logic        last;
  } prod_t;

  function automatic prod_t pk(input logic [31:0] v, input logic [15:0] r,
                               input logic [15:0] c, input logic l);
    return '{val: v, row: r, col: c, last: l};
  endfunction

  function automatic prod_t cur_out();
    return '{val: out_val, row: out_row, col: out_col, last: out_last};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] v, input logic [15:0] r, input logic [15:0] c,
                        input logic l);
    a_valid = 1'b1;
    a_val   = v;
    a_row   = r;
    a_col   = c;
    a_last  = l;
  endtask

  // Scoreboard monitor: expected products in issue order, stall stability, done pulses.
  prod_t exp_q [$];
  bit    mon_en = 1'b0;
  int    done_cnt = 0;
  bit    prev_stall = 1'b0;
  prod_t prev_out;
  prod_t mon_cur;
  prod_t mon_exp;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      mon_cur = cur_out();
      if (prev_stall) check_eq("stall_hold", mon_cur, prev_out);
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_product", out_valid, 1'b0);
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq("product", mon_cur, mon_exp);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = mon_cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int n;
    int na;
    logic [31:0] v;
    logic [15:0] r;
    logic [15:0] c;
    logic [63:0] full;
    bit hs;

    for (int i = 0; i <= 16; i++) rowptr[i] = 0;
    for (int i = 0; i < 64; i++) begin
      bval[i] = '0;
      bcol[i] = '0;
    end

    // Reset state, with a_valid high to prove nothing is accepted.
    a_valid = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check_eq("rst_a_ready", a_ready, 1'b0);
    check_eq("rst_b_rp_en", b_rp_en, 1'b0);
    check_eq("rst_b_el_en", b_el_en, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_out_fields", {out_val, out_row, out_col}, 64'd0);
    a_valid = 1'b0;
    rst_n   = 1'b1;
    cyc();
    #2;
    check_eq("rel_a_ready", a_ready, 1'b1);

    // Three-element B row, full-speed drain.
    rowptr[5] = 10;
    rowptr[6] = 13;
    bval[10] = 7; bcol[10] = 1;
    bval[11] = 2; bcol[11] = 4;
    bval[12] = 5; bcol[12] = 9;
    cyc(); send_a(3, 2, 5, 1'b1); #2;
    check_eq("t42_rp_en", b_rp_en, 1'b1);
    check_eq("t42_rp_addr", b_rp_addr, 16'd5);
    cyc(); a_valid = 1'b0; #2;
    check_eq("t42_ptr_busy", a_ready, 1'b0);
    cyc(); #2;
    check_eq("t42_el_en_t2", b_el_en, 1'b1);
    check_eq("t42_el_addr_t2", b_el_addr, 16'd10);
    cyc(); #2;
    check_eq("t42_el_addr_t3", b_el_addr, 16'd11);
    check_eq("t42_no_out_t3", out_valid, 1'b0);
    cyc(); #2;
    check_eq("t42_valid_t4", out_valid, 1'b1);
    check_eq("t42_out_t4", cur_out(), pk(21, 2, 1, 1'b0));
    cyc(); #2;
    check_eq("t42_out_t5", cur_out(), pk(6, 2, 4, 1'b0));
    cyc(); #2;
    check_eq("t42_out_t6", cur_out(), pk(15, 2, 9, 1'b1));
    check_eq("t42_done_t6", done, 1'b1);
    cyc(); #2;
    check_eq("t42_empty_t7", out_valid, 1'b0);
    check_eq("t42_done_t7", done, 1'b0);
    check_eq("t42_idle_t7", a_ready, 1'b1);

    // Same row, downstream stalls for T+3..T+8.
    cyc(); send_a(3, 2, 5, 1'b1);
    cyc(); a_valid = 1'b0;
    cyc(); #2;
    check_eq("t43_el_en_t2", b_el_en, 1'b1);
    cyc(); ready_force = 1'b0; #2;
    check_eq("t43_el_addr_t3", b_el_addr, 16'd11);
    for (int k = 4; k <= 8; k++) begin
      cyc(); #2;
      check_eq("t43_el_stopped", b_el_en, 1'b0);
      check_eq("t43_head_held", {out_valid, cur_out()}, {1'b1, pk(21, 2, 1, 1'b0)});
    end
    cyc(); ready_force = 1'b1; #2;
    check_eq("t43_out_t9", cur_out(), pk(21, 2, 1, 1'b0));
    check_eq("t43_resume_addr", {b_el_en, b_el_addr}, {1'b1, 16'd12});
    cyc(); #2;
    check_eq("t43_out_t10", cur_out(), pk(6, 2, 4, 1'b0));
    cyc(); #2;
    check_eq("t43_out_t11", cur_out(), pk(15, 2, 9, 1'b1));
    check_eq("t43_done", done, 1'b1);
    cyc(); #2;
    check_eq("t43_empty", out_valid, 1'b0);

    // Empty B row that closes the matrix.
    rowptr[4] = 8;
    rowptr[5] = 8;
    cyc(); send_a(9, 1, 4, 1'b1); #2;
    check_eq("t44_rp_en", b_rp_en, 1'b1);
    cyc(); a_valid = 1'b0; #2;
    check_eq("t44_done_t1", done, 1'b1);
    check_eq("t44_no_el_t1", b_el_en, 1'b0);
    cyc(); #2;
    check_eq("t44_done_t2", done, 1'b0);
    check_eq("t44_idle_t2", {a_ready, b_el_en, out_valid}, 3'b100);

    // Product wraps modulo 2^32.
    rowptr[7] = 20;
    rowptr[8] = 21;
    bval[20] = 32'h0001_0000;
    bcol[20] = 3;
    cyc(); send_a(32'h0001_0000, 6, 7, 1'b1);
    cyc(); a_valid = 1'b0;
    cyc();
    cyc();
    cyc(); #2;
    check_eq("t46_wrap", {out_valid, cur_out()}, {1'b1, pk(0, 6, 3, 1'b1)});
    cyc(); #2;

    // Reset mid-stream after the first product.
    rowptr[9]  = 30;
    rowptr[10] = 34;
    for (int i = 30; i < 34; i++) begin
      bval[i] = 32'(i);
      bcol[i] = 16'(i);
    end
    cyc(); send_a(2, 3, 9, 1'b1);
    cyc(); a_valid = 1'b0;
    cyc();
    cyc();
    cyc(); #2;
    check_eq("t47_first", {out_valid, cur_out()}, {1'b1, pk(60, 3, 30, 1'b0)});
    cyc(); #2;
    rst_n = 1'b0;
    #1;
    check_eq("t47_rst_valid", out_valid, 1'b0);
    check_eq("t47_rst_ready", a_ready, 1'b0);
    check_eq("t47_rst_el_en", b_el_en, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc(); #2;
    check_eq("t47_rel_ready", a_ready, 1'b1);
    seen = 0;
    repeat (10) begin
      cyc(); #2;
      if (out_valid || b_el_en) seen++;
    end
    check_eq("t47_no_stale", seen, 0);

    // Randomized matrices against the reference model.
    mon_en     = 1'b1;
    rand_ready = 1'b1;
    done_cnt   = 0;
    for (int it = 0; it < 20; it++) begin
      rowptr[0] = 0;
      for (int i = 0; i < 16; i++) rowptr[i+1] = rowptr[i] + $urandom_range(0, 3);
      for (int i = 0; i < 64; i++) begin
        bval[i] = (it % 4 == 0) ? 32'($urandom_range(0, 3)) << 16 : $urandom;
        bcol[i] = 16'($urandom);
      end
      na = $urandom_range(1, 6);
      for (int j = 0; j < na; j++) begin
        v = (it % 4 == 0) ? 32'($urandom_range(0, 3)) << 16 : $urandom;
        r = 16'($urandom);
        c = 16'($urandom_range(0, 15));
        for (int unsigned p = rowptr[c]; p < rowptr[c+1]; p++) begin
          full = 64'(v) * 64'(bval[p]);
          exp_q.push_back(pk(full[31:0], r, bcol[p], (j == na - 1) && (p == rowptr[c+1] - 1)));
        end
        send_a(v, r, c, j == na - 1);
        n = 0;
        do begin
          #2;
          hs = a_ready;
          cyc();
          n++;
        end while (!hs && n < 200);
        if (!hs) check_eq("rand_a_accept_timeout", hs, 1'b1);
        a_valid = 1'b0;
        repeat ($urandom_range(0, 2)) cyc();
      end
      n = 0;
      do begin
        cyc();
        n++;
      end while (exp_q.size() != 0 && n < 400);
      check_eq("rand_drained", exp_q.size(), 0);
      check_eq("rand_done_count", done_cnt, it + 1);
      cyc();
    end
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
